// File: rtl/spi_reg_ctrl_if.sv
// Byte-receiver side and register-bank side of the SPI command sequencer.
interface spi_reg_ctrl_if #(parameter int ADDR_W = 4);
  logic              cs_n;
  logic [7:0]        rx_data;
  logic              rx_stb;
  logic              rx_err;
  logic              wr_enable;
  logic              reg_we;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              busy;
  logic [7:0]        frame_cnt;
  logic [7:0]        err_cnt;

  modport slave (
    input  cs_n, rx_data, rx_stb, rx_err, wr_enable,
    output reg_we, reg_addr, reg_wdata, busy, frame_cnt, err_cnt
  );

  modport master (
    output cs_n, rx_data, rx_stb, rx_err, wr_enable,
    input  reg_we, reg_addr, reg_wdata, busy, frame_cnt, err_cnt
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// Turns SPI frames (cmd, addr, data...) into auto-incrementing register writes.
// One-cycle latency from rx_stb to reg_we; accepts a byte every cycle, never stalls.
module spi_reg_ctrl #(
  parameter int         ADDR_W = 4,
  parameter logic [7:0] CMD_WR = 8'h57
) (
  input logic            sys_clk,
  input logic            sys_rst,
  spi_reg_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DISCARD} state_t;

  state_t            state, state_nxt, after_byte;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [7:0]        wcnt, wcnt_nxt;
  logic              we_q, we_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [7:0]        wdata_q, wdata_nxt;
  logic              busy_q;
  logic [7:0]        frame_q, err_q;
  logic              frame_inc, err_inc;

  always_comb begin
    state_nxt  = state;
    after_byte = state;
    ptr_nxt    = ptr;
    wcnt_nxt   = wcnt;
    we_nxt     = 1'b0;
    addr_nxt   = addr_q;
    wdata_nxt  = wdata_q;
    frame_inc  = 1'b0;
    err_inc    = 1'b0;

    case (state)
      IDLE: begin
        if (!bus.cs_n) begin
          state_nxt = CMD;
          wcnt_nxt  = 8'd0;
        end
      end
      CMD: begin
        if (bus.rx_err) begin
          state_nxt = DISCARD;
          err_inc   = 1'b1;
        end else if (bus.rx_stb) begin
          if (bus.rx_data == CMD_WR && bus.wr_enable) begin
            state_nxt = ADDR;
          end else begin
            state_nxt = DISCARD;
            err_inc   = 1'b1;
          end
        end
      end
      ADDR: begin
        if (bus.rx_err) begin
          state_nxt = DISCARD;
          err_inc   = 1'b1;
        end else if (bus.rx_stb) begin
          if ((bus.rx_data >> ADDR_W) == 8'd0) begin
            ptr_nxt   = bus.rx_data[ADDR_W-1:0];
            state_nxt = DATA;
          end else begin
            state_nxt = DISCARD;
            err_inc   = 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.rx_err) begin
          state_nxt = DISCARD;
          err_inc   = 1'b1;
        end else if (bus.rx_stb) begin
          we_nxt    = 1'b1;
          addr_nxt  = ptr;
          wdata_nxt = bus.rx_data;
          ptr_nxt   = ptr + 1'b1;
          if (wcnt != 8'hFF) wcnt_nxt = wcnt + 8'd1;
        end
      end
      default: ;
    endcase

    // Frame end is classified on the state reached after any byte on this same edge.
    if (bus.cs_n && state != IDLE) begin
      after_byte = state_nxt;
      state_nxt  = IDLE;
      if (after_byte == DATA) begin
        if (wcnt_nxt != 8'd0) frame_inc = 1'b1;
        else                  err_inc   = 1'b1;
      end else if (after_byte == ADDR) begin
        err_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= IDLE;
      ptr     <= '0;
      wcnt    <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 8'd0;
      busy_q  <= 1'b0;
      frame_q <= 8'd0;
      err_q   <= 8'd0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      wcnt    <= wcnt_nxt;
      we_q    <= we_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      busy_q  <= (state_nxt != IDLE);
      if (frame_inc && frame_q != 8'hFF) frame_q <= frame_q + 8'd1;
      if (err_inc && err_q != 8'hFF)     err_q   <= err_q + 8'd1;
    end
  end

  assign bus.reg_we    = we_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.frame_cnt = frame_q;
  assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: hand-computed frames, counters and strobes.
module tb_spi_reg_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int we_seen = 0;

  spi_reg_ctrl_if #(.ADDR_W(4)) bus();

  spi_reg_ctrl #(.ADDR_W(4), .CMD_WR(8'h57)) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Counts strobes mid-cycle so tests can assert on how many writes happened.
  always @(negedge clk) if (bus.reg_we === 1'b1) we_seen++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    bus.rx_data = d;
    bus.rx_stb  = 1'b1;
    step();
    bus.rx_stb  = 1'b0;
  endtask

  task automatic cs_lo();
    bus.cs_n = 1'b0;
    step();
  endtask

  task automatic cs_hi();
    bus.cs_n = 1'b1;
    step();
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cs_n = 1'b1;
    bus.rx_stb = 1'b0;
    bus.rx_err = 1'b0;
    bus.wr_enable = 1'b1;
    step();
    rst = 1'b0;
    step();
    we_seen = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if (bus.reg_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", bus.reg_we); end
    total++; if (bus.reg_addr !== 4'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", bus.reg_addr); end
    total++; if (bus.reg_wdata !== 8'h00) begin bad++; $display("FAIL reset_wdata got=%h exp=00", bus.reg_wdata); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.frame_cnt !== 8'h00) begin bad++; $display("FAIL reset_frame got=%h exp=00", bus.frame_cnt); end
    total++; if (bus.err_cnt !== 8'h00) begin bad++; $display("FAIL reset_err got=%h exp=00", bus.err_cnt); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_good_burst();
    logic [3:0] ea [3] = '{4'h3, 4'h4, 4'h5};
    logic [7:0] ed [3] = '{8'hAA, 8'hBB, 8'hCC};
    do_reset();
    cs_lo();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL burst_busy_rise got=%b exp=1", bus.busy); end
    send(8'h57);
    send(8'h03);
    total++; if (bus.reg_we !== 1'b0) begin bad++; $display("FAIL burst_no_we_hdr got=%b exp=0", bus.reg_we); end
    for (int i = 0; i < 3; i++) begin
      send(ed[i]);
      total++;
      if (bus.reg_we !== 1'b1 || bus.reg_addr !== ea[i] || bus.reg_wdata !== ed[i]) begin
        bad++;
        $display("FAIL burst_write%0d got we=%b a=%h d=%h exp we=1 a=%h d=%h", i, bus.reg_we, bus.reg_addr, bus.reg_wdata, ea[i], ed[i]);
      end
    end
    bus.cs_n = 1'b1;
    step();
    total++; if (bus.reg_we !== 1'b0) begin bad++; $display("FAIL burst_we_one_cycle got=%b exp=0", bus.reg_we); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL burst_busy_fall got=%b exp=0", bus.busy); end
    step();
    total++; if (bus.frame_cnt !== 8'd1 || bus.err_cnt !== 8'd0) begin bad++; $display("FAIL burst_counts got f=%0d e=%0d exp f=1 e=0", bus.frame_cnt, bus.err_cnt); end
    total++; if (we_seen !== 3) begin bad++; $display("FAIL burst_we_count got=%0d exp=3", we_seen); end
  endtask

  task automatic test_wrap();
    do_reset();
    cs_lo();
    send(8'h57);
    bus.wr_enable = 1'b0;  // mid-burst change must not stop the burst
    send(8'h0F);
    send(8'h11);
    total++; if (bus.reg_we !== 1'b1 || bus.reg_addr !== 4'hF || bus.reg_wdata !== 8'h11) begin bad++; $display("FAIL wrap_first got a=%h d=%h exp a=f d=11", bus.reg_addr, bus.reg_wdata); end
    send(8'h22);
    total++; if (bus.reg_we !== 1'b1 || bus.reg_addr !== 4'h0 || bus.reg_wdata !== 8'h22) begin bad++; $display("FAIL wrap_second got a=%h d=%h exp a=0 d=22", bus.reg_addr, bus.reg_wdata); end
    cs_hi();
    bus.wr_enable = 1'b1;
    total++; if (bus.frame_cnt !== 8'd1) begin bad++; $display("FAIL wrap_frame got=%0d exp=1", bus.frame_cnt); end
  endtask

  task automatic test_bad_frames();
    // opcode 12
    do_reset();
    cs_lo(); send(8'h12); send(8'h00); send(8'h55); cs_hi();
    total++; if (we_seen !== 0 || bus.err_cnt !== 8'd1 || bus.frame_cnt !== 8'd0) begin bad++; $display("FAIL bad_opcode got we=%0d e=%0d f=%0d exp 0 1 0", we_seen, bus.err_cnt, bus.frame_cnt); end
    // address out of range
    do_reset();
    cs_lo(); send(8'h57); send(8'h10); send(8'hAA); cs_hi();
    total++; if (we_seen !== 0 || bus.err_cnt !== 8'd1) begin bad++; $display("FAIL bad_addr got we=%0d e=%0d exp 0 1", we_seen, bus.err_cnt); end
    // truncated after address
    do_reset();
    cs_lo(); send(8'h57); send(8'h03); cs_hi();
    total++; if (bus.err_cnt !== 8'd1 || bus.frame_cnt !== 8'd0) begin bad++; $display("FAIL truncated got e=%0d f=%0d exp 1 0", bus.err_cnt, bus.frame_cnt); end
    // writes disabled
    do_reset();
    bus.wr_enable = 1'b0;
    cs_lo(); send(8'h57); send(8'h00); send(8'h55); cs_hi();
    bus.wr_enable = 1'b1;
    total++; if (we_seen !== 0 || bus.err_cnt !== 8'd1) begin bad++; $display("FAIL wr_disabled got we=%0d e=%0d exp 0 1", we_seen, bus.err_cnt); end
    // empty single-cycle frame
    do_reset();
    cs_lo(); cs_hi();
    total++; if (bus.err_cnt !== 8'd0 || bus.frame_cnt !== 8'd0 || bus.busy !== 1'b0) begin bad++; $display("FAIL empty_frame got e=%0d f=%0d b=%b exp 0 0 0", bus.err_cnt, bus.frame_cnt, bus.busy); end
  endtask

  task automatic test_rx_err();
    do_reset();
    cs_lo(); send(8'h57); send(8'h00); send(8'h01);
    bus.rx_err = 1'b1; step(); bus.rx_err = 1'b0;
    send(8'h02);
    cs_hi();
    total++; if (we_seen !== 1 || bus.err_cnt !== 8'd1 || bus.frame_cnt !== 8'd0) begin bad++; $display("FAIL rx_err_mid got we=%0d e=%0d f=%0d exp 1 1 0", we_seen, bus.err_cnt, bus.frame_cnt); end
    cs_lo(); send(8'h57); send(8'h00);
    bus.rx_err = 1'b1; send(8'h09); bus.rx_err = 1'b0;
    total++; if (bus.reg_we !== 1'b0) begin bad++; $display("FAIL stb_err_drop got=%b exp=0", bus.reg_we); end
    cs_hi();
    total++; if (we_seen !== 1 || bus.err_cnt !== 8'd2 || bus.frame_cnt !== 8'd0) begin bad++; $display("FAIL stb_err_counts got we=%0d e=%0d f=%0d exp 1 2 0", we_seen, bus.err_cnt, bus.frame_cnt); end
    // rx_err coincident with cs_n rising counts once
    cs_lo(); send(8'h57);
    bus.rx_err = 1'b1; bus.cs_n = 1'b1; step(); bus.rx_err = 1'b0; step();
    total++; if (bus.err_cnt !== 8'd3 || bus.busy !== 1'b0) begin bad++; $display("FAIL err_cs_once got e=%0d b=%b exp 3 0", bus.err_cnt, bus.busy); end
  endtask

  task automatic test_stb_cs_coincident();
    do_reset();
    cs_lo(); send(8'h57); send(8'h02);
    bus.cs_n = 1'b1;
    send(8'h77);
    total++; if (bus.reg_we !== 1'b1 || bus.reg_addr !== 4'h2 || bus.reg_wdata !== 8'h77) begin bad++; $display("FAIL stb_cs_write got we=%b a=%h d=%h exp 1 2 77", bus.reg_we, bus.reg_addr, bus.reg_wdata); end
    total++; if (bus.frame_cnt !== 8'd1 || bus.busy !== 1'b0 || bus.err_cnt !== 8'd0) begin bad++; $display("FAIL stb_cs_counts got f=%0d b=%b e=%0d exp 1 0 0", bus.frame_cnt, bus.busy, bus.err_cnt); end
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    cs_lo(); send(8'h57); send(8'h00); send(8'h01);
    rst = 1'b1;
    send(8'h02);
    rst = 1'b0;
    total++; if (bus.reg_we !== 1'b0 || bus.reg_addr !== 4'h0 || bus.reg_wdata !== 8'h00 || bus.busy !== 1'b0 || bus.frame_cnt !== 8'd0 || bus.err_cnt !== 8'd0) begin
      bad++; $display("FAIL reset_mid got we=%b a=%h d=%h b=%b f=%0d e=%0d exp all zero", bus.reg_we, bus.reg_addr, bus.reg_wdata, bus.busy, bus.frame_cnt, bus.err_cnt);
    end
    step();
    total++; if (bus.busy !== 1'b1 || bus.reg_we !== 1'b0) begin bad++; $display("FAIL reset_mid_reenter got b=%b we=%b exp 1 0", bus.busy, bus.reg_we); end
    cs_hi();
    total++; if (we_seen !== 1) begin bad++; $display("FAIL reset_mid_we_count got=%0d exp=1", we_seen); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      cs_lo(); send(8'h57); send(8'h00); send(8'hAB); cs_hi();
      if (i == 254) begin
        total++; if (bus.frame_cnt !== 8'hFF) begin bad++; $display("FAIL sat_255 got=%h exp=ff", bus.frame_cnt); end
      end
    end
    total++; if (bus.frame_cnt !== 8'hFF || bus.err_cnt !== 8'h00) begin bad++; $display("FAIL sat_256 got f=%h e=%h exp ff 00", bus.frame_cnt, bus.err_cnt); end
  endtask

  initial begin
    bus.cs_n = 1'b1;
    bus.rx_data = 8'h00;
    bus.rx_stb = 1'b0;
    bus.rx_err = 1'b0;
    bus.wr_enable = 1'b1;
    test_reset();
    test_good_burst();
    test_wrap();
    test_bad_frames();
    test_rx_err();
    test_stb_cs_coincident();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Command sequencer behind the SPI slave byte receiver. It turns the received byte stream into register-bank write transactions. Each chip-select frame carries a command byte, a start address and one or more data bytes; the block issues one write strobe per data byte and auto-increments the address. Malformed or aborted frames are discarded and counted. It sits between the SPI slave and the configuration register bank, in the sys_clk domain.

## Interface
Parameters:
- ADDR_W, default 4: register address width; the bank holds 2^ADDR_W byte registers (ADDR_W ≤ 8).
- CMD_WR, default 8'h57: opcode of the burst-write command.

Ports:
- sys_clk  in  1: system clock. The single clock; all logic is on its rising edge.
- sys_rst  in  1: reset, synchronous and active-high.
- cs_n  in  1: chip select, already synchronized to sys_clk, active-low (1 = bus idle).
- rx_data  in  8: received byte, valid only while rx_stb=1.
- rx_stb  in  1: one-cycle pulse per completed received byte.
- rx_err  in  1: one-cycle pulse on a receiver framing error.
- wr_enable  in  1: write permission. When 0, write commands are rejected.
- reg_we  out  1: one-cycle register write strobe.
- reg_addr  out  ADDR_W: write address; valid while reg_we=1.
- reg_wdata  out  8: write data; valid while reg_we=1.
- busy  out  1: high when state ≠ IDLE.
- frame_cnt  out  8: count of good frames; saturates at 8'hFF.
- err_cnt  out  8: count of bad frames; saturates at 8'hFF.

## Operation
- All outputs are registered. Reset drives the following: state=IDLE, reg_we=0, reg_addr=0, reg_wdata=0, busy=0, frame_cnt=0, err_cnt=0, internal address pointer=0, per-frame write count=0.
- States: IDLE, CMD, ADDR, DATA, DISCARD.
- IDLE:
  - cs_n=0 → CMD; clear the per-frame write count.
  - rx_stb/rx_err are ignored while in IDLE.
- CMD, on rx_stb:
  - rx_data==CMD_WR and wr_enable=1 → ADDR.
  - Any other byte, or wr_enable=0 → DISCARD; err_cnt+1.
- ADDR, on rx_stb:
  - rx_data[7:ADDR_W]==0 → pointer=rx_data[ADDR_W-1:0]; → DATA.
  - Otherwise → DISCARD; err_cnt+1.
- DATA, on rx_stb:
  - Next cycle: reg_we=1, reg_addr=pointer, reg_wdata=rx_data.
  - Pointer then increments modulo 2^ADDR_W (wrap to 0).
  - Write count increments, saturating.
  - Writes are committed immediately; an aborted frame does not roll them back.
- DISCARD: all bytes are ignored until cs_n=1.
- cs_n=1 in any non-IDLE state → IDLE, and the frame is classified:
  - From DATA with write count ≥1: frame_cnt+1.
  - From DATA with count 0, or from ADDR: err_cnt+1 (truncated frame).
  - From CMD (empty frame): no count change.
  - From DISCARD: no further count (the error was already counted).
- rx_err in CMD/ADDR/DATA → DISCARD; err_cnt+1. rx_err in DISCARD or IDLE: no effect.
- Simultaneous events:
  - rx_stb and rx_err in the same cycle: the error wins and the byte is dropped.
  - rx_stb and cs_n=1 in the same cycle: the byte is processed first (a DATA byte still writes and counts toward the write count), then classification runs, then → IDLE, all on that edge.
  - rx_err and cs_n=1 in the same cycle: err_cnt+1 exactly once; → IDLE.
- wr_enable is sampled only at the command byte; a change mid-burst does not stop the burst.
- sys_rst mid-frame: immediate return to reset values. No strobe is issued for a byte pending on that edge. Because reset clears busy and state goes to IDLE, a still-low cs_n re-enters CMD on the next cycle.

## Timing
- rx_stb in cycle N → reg_we in cycle N+1, high for exactly one cycle.
- Maximum throughput: one write per cycle. Back-to-back rx_stb pulses must be supported.
- busy rises the cycle after cs_n is first seen low, and falls the cycle after cs_n is seen high.
- Counter updates become visible one cycle after the causing event.
- cs_n low for a single cycle with no bytes: CMD entered and left with no count change.

## Test plan
- Good burst, ADDR_W=4: frame 57,03,AA,BB,CC then cs_n=1 → three strobes at (3,AA),(4,BB),(5,CC), each 1 cycle after its rx_stb; frame_cnt=1; err_cnt=0.
- Address wrap: 57,0F,11,22 → writes (F,11),(0,22).
- Bad frames:
  - Opcode 12 → no reg_we; err_cnt=1.
  - Address 8'h10 → no reg_we; err_cnt=1.
  - Frame 57,03 then cs_n=1 → err_cnt=1.
  - wr_enable=0 with 57,00,55 → no write; err_cnt=1.
- rx_err mid-DATA: 57,00,01, rx_err, 02 → exactly one write (0,01); err_cnt=1; frame_cnt=0. A simultaneous rx_stb+rx_err drops the byte.
- Edge cases:
  - Final byte's rx_stb coincident with cs_n rising → the write still occurs and frame_cnt increments.
  - sys_rst asserted in DATA → all outputs are zero the next cycle and no strobe is emitted.
  - 256 good frames → frame_cnt saturates at FF.
